mem_stage_mc: RTL and testbench

Parametrised memory stage for the 16-bit pipelined core: next-PC selection plus a word-addressed data memory with configurable multi-cycle access latency. Sits between execute and write-back. Drives a `stall` to the hazard unit while an access is in flight and presents load data with a one-cycle `done` strobe. Successor to the single-cycle memory stage. It adds width and depth parameters, programmable latency, a stall handshake and misalignment detection.

---
 rtl/mem_stage_mc.sv | 122 ++++++++++++
 tb/tb_mem_stage_mc.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage_mc.sv
// mem_stage_mc: next-PC select plus word-addressed data memory with a
// programmable multi-cycle access latency, stall handshake and misalign check.
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   branch, jmpdsp, ALUJmp next-PC selects (ALUJmp has priority)
//   alu                   byte address for memory, or jump target
//   SgnExt, pc2           displacement and PC+2 for next-PC arithmetic
//   readData2             store data
//   enable, MemWrt        access request; MemWrt=1 store, 0 load
//   newPC                 next PC (combinational)
//   MemRead               registered load data, holds until next load
//   stall                 hold the pipeline while an access is in flight
//   done                  one-cycle access-complete strobe
//   err                   misaligned request strobe (combinational)
module mem_stage_mc #(
  parameter int WIDTH   = 16,
  parameter int DEPTH   = 256,
  parameter int LATENCY = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             branch,
  input  logic             jmpdsp,
  input  logic             ALUJmp,
  input  logic [WIDTH-1:0] alu,
  input  logic [WIDTH-1:0] SgnExt,
  input  logic [WIDTH-1:0] pc2,
  input  logic [WIDTH-1:0] readData2,
  input  logic             enable,
  input  logic             MemWrt,
  output logic [WIDTH-1:0] newPC,
  output logic [WIDTH-1:0] MemRead,
  output logic             stall,
  output logic             done,
  output logic             err
);

  localparam int ADDR_W = $clog2(DEPTH);
  localparam int CW     = $clog2(LATENCY + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]        state;
  logic [CW-1:0]     cnt;
  logic [ADDR_W-1:0] idx;
  logic [ADDR_W-1:0] idx_q;
  logic [WIDTH-1:0]  dat_q;
  logic              wr_q;
  logic              accept;
  logic              fire;
  logic [WIDTH-1:0]  mem [DEPTH];

  always_comb begin
    newPC = pc2;
    if (ALUJmp)
      newPC = alu;
    else if (branch | jmpdsp)
      newPC = pc2 + SgnExt;
  end

  // Upper address bits are dropped, so addresses wrap modulo DEPTH words.
  assign idx = alu[ADDR_W:1];

  assign accept = !rst && (state == S_IDLE)
                  && enable && !alu[0];
  assign fire   = !rst && (state == S_BUSY)
                  && (cnt == '0);

  assign stall = accept
                 || (!rst && (state == S_BUSY));
  assign err   = !rst && (state == S_IDLE)
                 && enable && alu[0];
  assign done  = !rst && (state == S_DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      cnt     <= '0;
      MemRead <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            cnt   <= CW'(LATENCY - 1);
            state <= S_BUSY;
          end
        end
        S_BUSY: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else begin
            if (!wr_q)
              MemRead <= mem[idx_q];
            state <= S_DONE;
          end
        end
        S_DONE: state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Request is captured at acceptance; inputs are ignored while busy.
  always_ff @(posedge clk) begin
    if (accept) begin
      idx_q <= idx;
      dat_q <= readData2;
      wr_q  <= MemWrt;
    end
  end

  // Memory is never cleared; fire is gated by rst so a
  // reset during BUSY discards the pending store.
  always_ff @(posedge clk) begin
    if (fire && wr_q)
      mem[idx_q] <= dat_q;
  end

endmodule

// File: tb/tb_mem_stage_mc.sv
// tb_mem_stage_mc: scoreboard bench for mem_stage_mc.
// Four instances (LATENCY 2,1,3,5) share inputs except enable.
module tb_mem_stage_mc;

  typedef struct {
    int          cyc;
    logic [15:0] d;
  } exp_t;

  localparam int LAT [4] = '{2, 1, 3, 5};

  logic        clk = 1'b0;
  logic        rst;
  logic        branch, jmpdsp, ALUJmp;
  logic [15:0] alu, SgnExt, pc2, readData2;
  logic        MemWrt;
  logic [3:0]  en;
  logic [15:0] np [4];
  logic [15:0] rd [4];
  logic [3:0]  stl, dn, er;

  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  int   scnt [4] = '{0, 0, 0, 0};
  exp_t q [4][$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mem_stage_mc #(.WIDTH(16), .DEPTH(256), .LATENCY(2)) u0 (
    .clk(clk), .rst(rst), .branch(branch), .jmpdsp(jmpdsp),
    .ALUJmp(ALUJmp), .alu(alu), .SgnExt(SgnExt), .pc2(pc2),
    .readData2(readData2), .enable(en[0]), .MemWrt(MemWrt),
    .newPC(np[0]), .MemRead(rd[0]), .stall(stl[0]),
    .done(dn[0]), .err(er[0]));

  mem_stage_mc #(.WIDTH(16), .DEPTH(256), .LATENCY(1)) u1 (
    .clk(clk), .rst(rst), .branch(branch), .jmpdsp(jmpdsp),
    .ALUJmp(ALUJmp), .alu(alu), .SgnExt(SgnExt), .pc2(pc2),
    .readData2(readData2), .enable(en[1]), .MemWrt(MemWrt),
    .newPC(np[1]), .MemRead(rd[1]), .stall(stl[1]),
    .done(dn[1]), .err(er[1]));

  mem_stage_mc #(.WIDTH(16), .DEPTH(256), .LATENCY(3)) u2 (
    .clk(clk), .rst(rst), .branch(branch), .jmpdsp(jmpdsp),
    .ALUJmp(ALUJmp), .alu(alu), .SgnExt(SgnExt), .pc2(pc2),
    .readData2(readData2), .enable(en[2]), .MemWrt(MemWrt),
    .newPC(np[2]), .MemRead(rd[2]), .stall(stl[2]),
    .done(dn[2]), .err(er[2]));

  mem_stage_mc #(.WIDTH(16), .DEPTH(256), .LATENCY(5)) u3 (
    .clk(clk), .rst(rst), .branch(branch), .jmpdsp(jmpdsp),
    .ALUJmp(ALUJmp), .alu(alu), .SgnExt(SgnExt), .pc2(pc2),
    .readData2(readData2), .enable(en[3]), .MemWrt(MemWrt),
    .newPC(np[3]), .MemRead(rd[3]), .stall(stl[3]),
    .done(dn[3]), .err(er[3]));

  task automatic chk(input string n, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", n, got, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one access on instance i; e is the MemRead expected at done.
  task automatic acc(input int i, input logic wr,
                     input logic [15:0] a, input logic [15:0] d,
                     input logic [15:0] e);
    alu = a; MemWrt = wr; readData2 = d; en[i] = 1'b1;
    q[i].push_back('{cyc + LAT[i] + 1, e});
    #1 chk($sformatf("stall_t0[%0d]", i), 32'(stl[i]), 1);
    for (int k = 1; k <= LAT[i] + 1; k++) begin
      tick();
      en[i] = 1'b0;
      #1;
      chk($sformatf("stall[%0d]", i), 32'(stl[i]), 32'(k <= LAT[i]));
      chk($sformatf("done[%0d]", i), 32'(dn[i]), 32'(k == LAT[i] + 1));
    end
    tick();
  endtask

  // Monitor: pop expected entry on every done and check cycle and data.
  always @(negedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 4; i++) begin
        if (stl[i]) scnt[i]++;
        if (dn[i]) begin
          if (q[i].size() == 0) begin
            total++;
            bad++;
            $display("FAIL done_unexp[%0d]: done at cycle %0d, none expected",
                     i, cyc);
          end else begin
            exp_t e;
            e = q[i].pop_front();
            chk($sformatf("done_cyc[%0d]", i), cyc, e.cyc);
            chk($sformatf("memread[%0d]", i), 32'(rd[i]), 32'(e.d));
          end
        end
      end
    end
  end

  initial begin
    int c0;
    int k [4];
    int base [4];
    rst = 1'b1; en = '0; MemWrt = 1'b0;
    alu = '0; readData2 = '0;
    pc2 = 16'h0003; SgnExt = 16'h0001;
    branch = 1'b1; jmpdsp = 1'b0; ALUJmp = 1'b0;
    tick();
    chk("pc_branch_in_rst", 32'(np[0]), 32'h0004);
    chk("stall_in_rst", 32'(stl[0]), 0);
    tick();
    rst = 1'b0;
    #1;
    chk("rst_memread", 32'(rd[0]), 0);
    chk("rst_stall", 32'(stl[0]), 0);
    chk("rst_done", 32'(dn[0]), 0);
    chk("rst_err", 32'(er[0]), 0);
    ALUJmp = 1'b1; alu = 16'h0040;
    #1 chk("pc_alujmp", 32'(np[0]), 32'h0040);
    ALUJmp = 1'b0; branch = 1'b0;
    #1 chk("pc_seq", 32'(np[0]), 32'h0003);
    pc2 = 16'hFFFE; SgnExt = 16'h0004; jmpdsp = 1'b1;
    #1 chk("pc_wrap", 32'(np[0]), 32'h0002);
    jmpdsp = 1'b0;
    tick();

    acc(0, 1'b1, 16'h0054, 16'h1234, 16'h0000);
    acc(0, 1'b0, 16'h0054, 16'h0000, 16'h1234);

    alu = 16'h0055; MemWrt = 1'b0; en[0] = 1'b1;
    #1;
    chk("mis_err", 32'(er[0]), 1);
    chk("mis_stall", 32'(stl[0]), 0);
    tick();
    chk("mis_err_held", 32'(er[0]), 1);
    en[0] = 1'b0;
    #1;
    chk("mis_err_drop", 32'(er[0]), 0);
    chk("mis_memread", 32'(rd[0]), 32'h1234);
    tick();
    acc(0, 1'b0, 16'h0054, 16'h0000, 16'h1234);

    acc(0, 1'b1, 16'h0202, 16'hBEEF, 16'h1234);
    acc(0, 1'b0, 16'h0002, 16'h0000, 16'hBEEF);

    acc(0, 1'b1, 16'h0010, 16'h5555, 16'hBEEF);
    alu = 16'h0010; MemWrt = 1'b1; readData2 = 16'hAAAA; en[0] = 1'b1;
    #1 chk("rs_stall_t0", 32'(stl[0]), 1);
    tick();
    en[0] = 1'b0; rst = 1'b1;
    #1;
    chk("rs_stall_rst", 32'(stl[0]), 0);
    chk("rs_done_rst", 32'(dn[0]), 0);
    tick();
    rst = 1'b0;
    #1;
    chk("rs_stall_after", 32'(stl[0]), 0);
    chk("rs_memread", 32'(rd[0]), 0);
    repeat (4) tick();
    acc(0, 1'b0, 16'h0010, 16'h0000, 16'h5555);

    for (int i = 1; i < 4; i++)
      acc(i, 1'b1, 16'h0054, 16'h0C30 + 16'(i), 16'h0000);

    // Back-to-back loads with enable held for 28 cycles.
    for (int i = 0; i < 4; i++) base[i] = scnt[i];
    c0 = cyc;
    alu = 16'h0054; MemWrt = 1'b0; en = 4'b1110;
    for (int i = 1; i < 4; i++) begin
      k[i] = 0;
      for (int c = 0; c < 28; c += LAT[i] + 2) begin
        q[i].push_back('{c0 + c + LAT[i] + 1, 16'h0C30 + 16'(i)});
        k[i]++;
      end
    end
    repeat (28) tick();
    en = '0;
    repeat (10) tick();
    for (int i = 1; i < 4; i++)
      chk($sformatf("sweep_stall_cnt[%0d]", i), scnt[i] - base[i],
          k[i] * (LAT[i] + 1));

    for (int i = 0; i < 4; i++)
      chk($sformatf("sb_empty[%0d]", i), q[i].size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
